// File: rtl/videocard_pkg.sv
// Shared types and defaults for the videocard host-side launcher.
package videocard_pkg;

  localparam int WIDTH_DEF   = 32;
  localparam int ROM_AW_DEF  = 16;
  localparam int TIMEOUT_DEF = 1048576;
  localparam int CNT_W_DEF   = $clog2(TIMEOUT_DEF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } launcher_state_t;

  // Timer must hold both START_CYCLES-1 and TIMEOUT-1.
  function automatic int timer_width(input int timeout, input int start_cycles);
    int w;
    w = $clog2(timeout);
    if ($clog2(start_cycles) > w) w = $clog2(start_cycles);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/launch_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
module launch_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/videocard_launcher.sv
// Streams a kernel program into the videocard ROM, pulses interrupt_start
// and waits for a completion edge or a timeout.
//
// state | meaning
// IDLE  | accept program words, wait for launch
// START | interrupt_start held for START_CYCLES cycles
// WAIT  | watch for interrupt_finish rising edge or timeout
module videocard_launcher
  import videocard_pkg::*;
#(
  parameter int WIDTH        = WIDTH_DEF,
  parameter int ROM_AW       = ROM_AW_DEF,
  parameter int START_CYCLES = 2,
  parameter int TIMEOUT      = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [WIDTH-1:0]  load_data,
  input  logic              load_last,
  input  logic              launch,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [ROM_AW:0]   prog_words,
  output logic [ROM_AW-1:0] address_rom,
  output logic [WIDTH-1:0]  data_in_rom,
  output logic              wren_rom,
  output logic              interrupt_start,
  input  logic              interrupt_finish
);

  localparam int TW = timer_width(TIMEOUT, START_CYCLES);

  launcher_state_t   state, state_nx;
  logic [ROM_AW-1:0] wr_ptr;
  logic              prog_valid;
  logic              finish_q;
  logic              hs;
  logic              finish_edge;
  logic              tmr_load;
  logic [TW-1:0]     tmr_val;
  logic              tmr_en;
  logic              tmr_expired;
  logic              done_nx;
  logic              timeout_nx;

  assign hs          = load_valid & load_ready;
  assign finish_edge = interrupt_finish & ~finish_q;
  assign tmr_en      = (state != IDLE);

  launch_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .expired  (tmr_expired)
  );

  always_comb begin
    state_nx   = state;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    done_nx    = 1'b0;
    timeout_nx = 1'b0;
    case (state)
      IDLE: begin
        // A load handshake in the same cycle wins over launch.
        if (launch && prog_valid && !hs) begin
          state_nx = START;
          tmr_load = 1'b1;
          tmr_val  = TW'(START_CYCLES - 1);
        end
      end
      START: begin
        if (tmr_expired) begin
          state_nx = WAIT;
          tmr_load = 1'b1;
          tmr_val  = TW'(TIMEOUT - 1);
        end
      end
      WAIT: begin
        if (finish_edge) begin
          done_nx  = 1'b1;
          state_nx = IDLE;
        end else if (tmr_expired) begin
          timeout_nx = 1'b1;
          state_nx   = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      wr_ptr          <= '0;
      prog_valid      <= 1'b0;
      finish_q        <= 1'b0;
      load_ready      <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      timeout         <= 1'b0;
      prog_words      <= '0;
      address_rom     <= '0;
      data_in_rom     <= '0;
      wren_rom        <= 1'b0;
      interrupt_start <= 1'b0;
    end else begin
      state           <= state_nx;
      finish_q        <= interrupt_finish;
      load_ready      <= (state_nx == IDLE);
      busy            <= (state_nx != IDLE);
      interrupt_start <= (state_nx == START);
      done            <= done_nx;
      timeout         <= timeout_nx;
      wren_rom        <= hs;
      if (hs) begin
        address_rom <= wr_ptr;
        data_in_rom <= load_data;
        if (load_last) begin
          prog_words <= {1'b0, wr_ptr} + (ROM_AW + 1)'(1);
          wr_ptr     <= '0;
          prog_valid <= 1'b1;
        end else begin
          wr_ptr     <= wr_ptr + ROM_AW'(1);
          prog_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_videocard_launcher.sv
// Randomized self-checking bench for videocard_launcher against a
// transaction-level model of load, launch, completion and timeout.
module tb_videocard_launcher;

  localparam int W  = 32;
  localparam int AW = 2;
  localparam int SC = 2;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          load_valid = 1'b0;
  logic          load_ready;
  logic [W-1:0]  load_data = '0;
  logic          load_last = 1'b0;
  logic          launch = 1'b0;
  logic          busy;
  logic          done;
  logic          timeout;
  logic [AW:0]   prog_words;
  logic [AW-1:0] address_rom;
  logic [W-1:0]  data_in_rom;
  logic          wren_rom;
  logic          interrupt_start;
  logic          interrupt_finish = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  // Model: next write address, last completed length, launchable program.
  int m_ptr = 0;
  int m_words = 0;
  bit m_valid = 1'b0;

  videocard_launcher #(
    .WIDTH(W), .ROM_AW(AW), .START_CYCLES(SC), .TIMEOUT(TO)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .load_valid       (load_valid),
    .load_ready       (load_ready),
    .load_data        (load_data),
    .load_last        (load_last),
    .launch           (launch),
    .busy             (busy),
    .done             (done),
    .timeout          (timeout),
    .prog_words       (prog_words),
    .address_rom      (address_rom),
    .data_in_rom      (data_in_rom),
    .wren_rom         (wren_rom),
    .interrupt_start  (interrupt_start),
    .interrupt_finish (interrupt_finish)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // base < 0 selects random data words.
  task automatic load_prog(input int n, input int base, input bit last);
    logic [W-1:0] d;
    int gap;
    for (int i = 0; i < n; i++) begin
      d = (base >= 0) ? W'(base + i) : W'($urandom);
      chk("load_ready_before_word", load_ready, 1);
      load_valid = 1'b1;
      load_data  = d;
      load_last  = last && (i == n - 1);
      tick();
      chk("wren_after_hs", wren_rom, 1);
      chk("address_rom", address_rom, m_ptr);
      chk("data_in_rom", data_in_rom, d);
      if (load_last) begin
        m_words = m_ptr + 1;
        m_ptr   = 0;
        m_valid = 1'b1;
      end else begin
        m_ptr   = (m_ptr + 1) % (1 << AW);
        m_valid = 1'b0;
      end
      load_valid = 1'b0;
      load_last  = 1'b0;
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        tick();
        chk("wren_idle_gap", wren_rom, 0);
      end
    end
    tick();
    chk("wren_after_load", wren_rom, 0);
    chk("prog_words", prog_words, m_words);
    chk("load_ready_after_load", load_ready, 1);
  endtask

  // Completion level per WAIT cycle w (index 0 = level during START).
  task automatic run_launch(input int edge_at, input bit stale);
    bit fin [0:TO];
    int e;
    int hi;
    bit exp_done;
    fin[0] = stale;
    for (int w = 1; w <= TO; w++)
      fin[w] = stale ? ((w < 3) || (w >= edge_at)) : (w >= edge_at);
    e = 0;
    for (int w = 1; w <= TO; w++) begin
      if (e == 0 && fin[w] && !fin[w-1]) e = w;
    end
    exp_done = (e != 0);
    if (e == 0) e = TO;

    interrupt_finish = fin[0];
    tick();
    launch = 1'b1;
    tick();
    launch = 1'b0;
    if (!m_valid) begin
      chk("ignored_launch_busy", busy, 0);
      chk("ignored_launch_istart", interrupt_start, 0);
      tick();
      chk("ignored_launch_busy2", busy, 0);
      interrupt_finish = 1'b0;
      return;
    end
    chk("launch_busy", busy, 1);
    chk("launch_istart", interrupt_start, 1);
    chk("launch_load_ready", load_ready, 0);
    hi = 1;
    while (interrupt_start && hi <= SC + 3) begin
      tick();
      if (interrupt_start) hi++;
    end
    chk("istart_length", hi, SC);
    chk("wait_busy", busy, 1);
    for (int w = 1; w <= e; w++) begin
      interrupt_finish = fin[w];
      tick();
      if (w < e) begin
        chk("done_early", done, 0);
        chk("timeout_early", timeout, 0);
        chk("busy_in_wait", busy, 1);
        chk("no_wren_busy", wren_rom, 0);
      end
    end
    chk("end_done", done, exp_done);
    chk("end_timeout", timeout, !exp_done);
    chk("end_busy", busy, 0);
    chk("end_load_ready", load_ready, 1);
    tick();
    chk("done_one_cycle", done, 0);
    chk("timeout_one_cycle", timeout, 0);
    interrupt_finish = 1'b0;
    tick();
  endtask

  initial begin
    int n, ea;
    bit last, stale;

    repeat (3) tick();
    chk("rst_load_ready", load_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_prog_words", prog_words, 0);
    chk("rst_address_rom", address_rom, 0);
    chk("rst_data_in_rom", data_in_rom, 0);
    chk("rst_wren", wren_rom, 0);
    chk("rst_istart", interrupt_start, 0);
    reset = 1'b0;
    tick();
    chk("post_rst_load_ready", load_ready, 1);

    run_launch(5, 0);                 // no program loaded
    load_prog(4, 'hA0, 1);
    run_launch(10, 0);

    // Launch together with a handshake is dropped even with a valid program.
    load_valid = 1'b1; load_last = 1'b1; load_data = W'($urandom); launch = 1'b1;
    tick();
    chk("hs_launch_wren", wren_rom, 1);
    chk("hs_launch_addr", address_rom, m_ptr);
    chk("hs_launch_data", data_in_rom, load_data);
    chk("hs_launch_istart", interrupt_start, 0);
    chk("hs_launch_busy", busy, 0);
    m_words = m_ptr + 1; m_ptr = 0; m_valid = 1'b1;
    load_valid = 1'b0; load_last = 1'b0; launch = 1'b0;
    tick();
    chk("hs_launch_busy2", busy, 0);
    chk("hs_launch_words", prog_words, m_words);

    run_launch(TO + 3, 0);            // timeout
    run_launch(TO, 0);                // edge on expiry cycle
    run_launch(8, 1);                 // stale high, fall, rise later
    run_launch(6, 0);                 // relaunch without reload

    load_prog(6, -1, 1);              // wraps address
    load_prog(4, -1, 1);              // last at top address
    load_prog(2, -1, 0);              // partial
    run_launch(4, 0);
    load_prog(3, -1, 1);
    run_launch(3, 0);

    // Reset during START.
    launch = 1'b1; tick(); launch = 1'b0;
    chk("pre_rst_istart", interrupt_start, 1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rst_start_istart", interrupt_start, 0);
    chk("rst_start_busy", busy, 0);
    m_valid = 1'b0; m_ptr = 0; m_words = 0;
    tick();
    run_launch(5, 0);

    // Reset during WAIT.
    load_prog(4, -1, 1);
    launch = 1'b1; tick(); launch = 1'b0;
    repeat (SC + 3) tick();
    chk("in_wait_busy", busy, 1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rst_wait_istart", interrupt_start, 0);
    chk("rst_wait_busy", busy, 0);
    chk("rst_wait_wren", wren_rom, 0);
    chk("rst_wait_load_ready", load_ready, 0);
    chk("rst_wait_prog_words", prog_words, 0);
    m_valid = 1'b0; m_ptr = 0; m_words = 0;
    tick();
    chk("rst_wait_ready_again", load_ready, 1);
    run_launch(5, 0);
    load_prog(2, -1, 1);
    run_launch(7, 0);

    for (int it = 0; it < 12; it++) begin
      n     = $urandom_range(1, 6);
      last  = ($urandom_range(0, 3) != 0);
      ea    = $urandom_range(1, TO + 3);
      stale = ($urandom_range(0, 3) == 0);
      load_prog(n, -1, last);
      run_launch(ea, stale);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no end expected end");
    $fatal(1);
  end

endmodule
